// File: rtl/mul_sequencer_pkg.sv
// Shared defines for the multiply sequencer: FSM state encoding and default operand width.
package mul_sequencer_pkg;

  localparam int unsigned MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers plus the
// registered result and {N, Z} flags, sequenced by load/step/commit strobes.
module mul_seq_dp
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             commit,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mult_q, mult_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       flags_q, flags_d;
  logic [WIDTH-1:0] acc_sum;

  // Carry out of the MSB is dropped: only the low WIDTH product bits are kept.
  always_comb begin
    acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);
  end

  always_comb begin
    mcand_d  = mcand_q;
    mult_d   = mult_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (load) begin
      mcand_d = a;
      mult_d  = b;
      acc_d   = '0;
    end else if (step) begin
      acc_d   = acc_sum;
      mcand_d = mcand_q << 1;
      mult_d  = mult_q >> 1;
    end
    // Commit coincides with the last step, so the final sum bypasses acc_q.
    if (commit) begin
      result_d = acc_sum;
      flags_d  = {acc_sum[WIDTH-1], (acc_sum == '0)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mult_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= 2'b01;
    end else begin
      mcand_q  <= mcand_d;
      mult_q   <= mult_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the multicycle core: fixed WIDTH+1 cycle
// latency, low WIDTH product bits and {N, Z} flags held until the next accept.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load, step, commit;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          load    = 1'b1;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        step    = 1'b1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          commit  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides everything, including a same-cycle start or final commit.
    if (flush) begin
      state_d = S_IDLE;
      load    = 1'b0;
      step    = 1'b0;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  mul_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (reset),
    .load   (load),
    .step   (step),
    .commit (commit),
    .a      (a),
    .b      (b),
    .result (result),
    .flags  (flags)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: vector table of products plus hand-built
// sequences for start-in-RUN, back-to-back, flush and asynchronous reset.
module tb_mul_sequencer;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         flush;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [1:0]   flags;

  int n_checks;
  int n_fail;

  mul_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_r;
    logic [1:0]   exp_f;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next cycle; outputs sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 drives the accept; cycles 1..W must be busy-only; cycle W+1 must be done with the result.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] exp_r, input logic [1:0] exp_f);
    int busy_cycles;
    busy_cycles = 0;
    start = 1'b1;
    a = va;
    b = vb;
    tick();
    start = 1'b0;
    a = '0;
    b = '0;
    for (int i = 1; i <= int'(W); i++) begin
      if (busy && !done) busy_cycles++;
      tick();
    end
    check({name, "_busy_cycles"}, W'(busy_cycles), W'(W));
    check({name, "_busy_end"}, W'(busy), W'(0));
    check({name, "_done"}, W'(done), W'(1));
    check({name, "_result"}, result, exp_r);
    check({name, "_flags"}, W'(flags), W'(exp_f));
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{32'd3,        32'd5,        32'd15,         2'b00};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   2'b00};
    vecs[2] = '{32'h80000000, 32'd1,        32'h80000000,   2'b10};
    vecs[3] = '{32'h00001234, 32'd0,        32'd0,          2'b01};
    vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001,   2'b10};
    vecs[5] = '{32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB,   2'b10};
    vecs[6] = '{32'h00010000, 32'h00010000, 32'd0,          2'b01};

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, W'(0));
    check("rst_flags", W'(flags), W'(2'b01));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_r, vecs[i].exp_f);
      tick();
      check($sformatf("vec%0d_idle_after", i), W'({busy, done}), W'(0));
    end

    // Start ignored in RUN, then back-to-back accept in the DONE cycle.
    start = 1'b1; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(W); c++) begin
      if (c == 10) begin start = 1'b1; a = 32'd7; b = 32'd9; end
      else begin start = 1'b0; a = '0; b = '0; end
      tick();
    end
    check("b2b_done1", W'(done), W'(1));
    check("b2b_result1", result, 32'd15);
    start = 1'b1; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0; a = '0; b = '0;
    cnt = 0;
    for (int c = int'(W) + 2; c <= 2 * int'(W) + 1; c++) begin
      if (busy && !done) cnt++;
      tick();
    end
    check("b2b_busy_cycles", W'(cnt), W'(W));
    check("b2b_done2", W'(done), W'(1));
    check("b2b_result2", result, 32'd42);
    check("b2b_flags2", W'(flags), W'(2'b00));
    tick();

    // Flush mid-RUN after a previous result of 15.
    run_op("pre_flush", 32'd3, 32'd5, 32'd15, 2'b00);
    tick();
    start = 1'b1; a = 32'd100; b = 32'd100;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", W'(busy), W'(0));
    check("flush_done", W'(done), W'(0));
    check("flush_result", result, 32'd15);
    cnt = 0;
    for (int c = 0; c < int'(W) + 4; c++) begin
      if (busy || done) cnt++;
      tick();
    end
    check("flush_quiet", W'(cnt), W'(0));

    // Flush together with start: no accept.
    start = 1'b1; flush = 1'b1; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", W'(busy), W'(0));
    tick();
    check("flush_start_busy2", W'(busy), W'(0));

    // Flush on the final RUN cycle must suppress the commit.
    start = 1'b1; a = 32'd4; b = 32'd4;
    tick();
    start = 1'b0;
    for (int c = 1; c < int'(W); c++) tick();
    check("flush_last_busy_before", W'(busy), W'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_last_done", W'(done), W'(0));
    check("flush_last_result", result, 32'd15);
    check("flush_last_flags", W'(flags), W'(2'b00));
    tick();

    // Asynchronous reset in RUN cycle 5.
    start = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("pre_reset_busy", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    check("areset_busy", W'(busy), W'(0));
    check("areset_done", W'(done), W'(0));
    check("areset_result", result, W'(0));
    check("areset_flags", W'(flags), W'(2'b01));
    tick();
    reset = 1'b0;
    tick();
    run_op("post_reset", 32'd11, 32'd13, 32'd143, 2'b00);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiply sequencer for the multicycle ARM core. It takes over multiplication from the single-cycle ALU path: the main control FSM pulses `start` from its multiply-execute state, holds there while `busy` is high, and moves to ALU writeback when `done` pulses. It produces the low WIDTH bits of the product (ARM MUL semantics) plus N/Z flags, registered and held until the next accepted operation.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; iteration count per operation.

Ports:
- `clk`  in  1  clock, all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `flush`  in  1  synchronous abort of the current operation.
- `a`  in  WIDTH  multiplicand (Rm), sampled on accept.
- `b`  in  WIDTH  multiplier (Rs), sampled on accept.
- `busy`  out  1  high in every RUN cycle.
- `done`  out  1  one-cycle pulse in the DONE state.
- `result`  out  WIDTH  low WIDTH bits of a*b, registered.
- `flags`  out  2  {N, Z} of `result`, registered with it.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start` high -> capture mcand=a, mult=b, acc=0, count=0; next state RUN.
- RUN, each cycle:
  - if mult[0], acc <= acc + mcand (mod 2^WIDTH);
  - mcand <= mcand << 1; mult <= mult >> 1; count <= count + 1.
  - When count == WIDTH-1, the final iteration is applied, `result` and `flags` load from the final acc, and the next state is DONE.
- DONE: `done`=1 for exactly one cycle.
  - `start` high -> accept (same capture as IDLE), next RUN.
  - Otherwise next IDLE.
- Width rules:
  - Accumulator is WIDTH bits; carry out of the MSB is discarded.
  - Result is identical for signed and unsigned operands.
  - N = result[WIDTH-1]; Z = (result == 0).
- `start` in RUN: ignored; operands are not resampled.
- `flush`: in any state, next state IDLE. No `done`; `result`/`flags` keep their previous values.
- `flush` and `start` in the same cycle: flush wins, no accept.
- Operand ports are don't-care outside the accept cycle.
- Reset values: state=IDLE, busy=0, done=0, result=0, flags=2'b01 (Z set, consistent with result=0); internal registers 0.
- Reset asserted mid-RUN: immediate return to IDLE, no `done`.

## Timing
- `start` high in cycle 0 (accepted):
  - `busy`=1 in cycles 1..WIDTH;
  - `done`=1 and new `result`/`flags` visible in cycle WIDTH+1.
- Latency is fixed at WIDTH+1 cycles, independent of operand values. No early termination.
- Back-to-back: `start` in the DONE cycle (WIDTH+1) gives `busy` in cycles WIDTH+2..2*WIDTH+1 and the next `done` in 2*WIDTH+2.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Structure
- Shared package (core-wide defines file) holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WIDTH=32, so the main FSM and datapath agree.
- One sub-module, `mul_seq_dp`:
  - holds the mcand/mult/acc shift-add registers and the result/flag registers;
  - driven by load/step/commit strobes from the sequencer FSM.
- The counter (clog2(WIDTH) bits) and the FSM stay in `mul_sequencer`.

## Test plan
- a=3, b=5, start in cycle 0 -> `busy` in cycles 1..32, `done` in cycle 33, result=15, flags=2'b00.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001, flags=2'b00; a=0x80000000, b=1 -> result=0x80000000, flags=2'b10.
- a=0x1234, b=0 -> result=0, flags=2'b01, latency still 33 cycles.
- start during RUN with new operands (cycle 10) -> ignored; the original product completes at cycle 33; a second start in the DONE cycle 33 -> next `done` at cycle 66 with the new operands' product.
- flush at cycle 10 of an operation with previous result=15 -> IDLE at cycle 11, no `done`, result stays 15; flush+start in the same cycle -> no accept.
- reset pulse at cycle 5 of RUN -> busy=0, done=0, result=0, flags=2'b01 immediately; a new start after reset release completes normally.
